soin_bpredictor_resolve: RTL

- Execute-side counterpart of the fetch-stage gshare/RAS predictor.
- Takes resolved branches from execute and compares the actual outcome with the predicted direction and target.
- On a mismatch it issues a one-cycle fetch redirect.
- It builds saturating-counter update records and RAS-recovery records, queues them in a small FIFO, and drives them onto the predictor's execute_bpredictor_* update port one per cycle while the predictor is not stalled.

---
 rtl/soin_bpredictor_resolve.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/soin_bpredictor_resolve.sv
// ---------------------------------------------------------------------------
// soin_bpredictor_resolve
//
// Execute-side resolve unit for the fetch-stage gshare/RAS predictor.
// Resolved branches are compared against what fetch predicted.  A mismatch
// produces a one-cycle fetch redirect and a short squash window.  In that
// window, wrong-path resolves are dropped.  Counter-update and RAS-recovery
// records are queued and drained to the predictor update port, one per
// cycle, whenever the predictor is not stalled.
//
// Ports
//   clk, reset (async, active low)
//   ex_*                      : resolved branch from execute (valid/ready)
//   soin_bpredictor_stall     : predictor busy, hold the queue head
//   fetch_redirect(_PC)       : registered redirect pulse and corrected PC
//   execute_bpredictor_*      : registered update record, strobed on pop
// ---------------------------------------------------------------------------
module soin_bpredictor_resolve #(
  parameter int META_W        = 18,
  parameter int FIFO_DEPTH    = 4,
  parameter int SQUASH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [31:0]       ex_PC,
  input  logic              ex_is_cond,
  input  logic              ex_is_call,
  input  logic              ex_is_ret,
  input  logic              ex_taken,
  input  logic [31:0]       ex_target,
  input  logic              ex_p_dir,
  input  logic [31:0]       ex_p_target,
  input  logic [META_W-1:0] ex_meta,
  input  logic              soin_bpredictor_stall,
  output logic              fetch_redirect,
  output logic [31:0]       fetch_redirect_PC,
  output logic              execute_bpredictor_update,
  output logic [31:0]       execute_bpredictor_PC,
  output logic [31:0]       execute_bpredictor_target,
  output logic              execute_bpredictor_dir,
  output logic              execute_bpredictor_miss,
  output logic [META_W-1:0] execute_bpredictor_meta,
  output logic              execute_bpredictor_recover_ras
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [3:0]       SQ_LOAD  = 4'(SQUASH_CYCLES);

  typedef struct packed {
    logic              upd;
    logic              rec;
    logic [31:0]       pc;
    logic [31:0]       target;
    logic              dir;
    logic              miss;
    logic [META_W-1:0] meta;
  } rec_t;

  // 2-bit saturating counter step in the actual direction
  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic taken);
    logic [1:0] r;
    if (taken) begin
      r = (c == 2'd3) ? 2'd3 : c + 2'd1;
    end else begin
      r = (c == 2'd0) ? 2'd0 : c - 2'd1;
    end
    return r;
  endfunction

  // RAS index as it should be after this branch retires (mod 16)
  function automatic logic [3:0] ras_fix(input logic [3:0] r, input logic call, input logic ret);
    return r + {3'd0, call} - {3'd0, ret};
  endfunction

  rec_t              mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_q, rd_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ready_q, ready_d;
  logic [3:0]        squash_q, squash_d;
  logic              redir_q;
  logic [31:0]       redir_pc_q;
  logic              upd_q, rec_q, dir_q, miss_q;
  logic [31:0]       pc_q, tgt_q;
  logic [META_W-1:0] meta_q;

  logic              acc_s, miss_s, push_s, pop_s;
  logic [31:0]       npc_s;
  rec_t              new_rec_s;

  // Accept, mispredict detection and record construction
  always_comb begin
    npc_s  = ex_PC + 32'd4;
    acc_s  = ex_valid & ready_q & (squash_q == 4'd0);
    miss_s = acc_s & ((ex_taken != ex_p_dir) |
                      (ex_taken & (ex_target != ex_p_target)) |
                      (~ex_taken & (ex_p_target != npc_s)));
    push_s = acc_s & (ex_is_cond | miss_s);
    pop_s  = (count_q != '0) & ~soin_bpredictor_stall;

    new_rec_s              = '0;
    new_rec_s.upd          = ex_is_cond;
    new_rec_s.rec          = miss_s;
    new_rec_s.pc           = ex_PC;
    new_rec_s.target       = ex_target;
    new_rec_s.dir          = ex_taken;
    new_rec_s.miss         = miss_s;
    new_rec_s.meta         = ex_meta;
    new_rec_s.meta[17:14]  = ras_fix(ex_meta[17:14], ex_is_call, ex_is_ret);
    new_rec_s.meta[13:12]  = sat_step(ex_meta[13:12], ex_taken);
  end

  // Occupancy, ready and squash next-state
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
    // ready is registered from the next occupancy, so a pop while full
    // does not reopen the input in the same cycle
    ready_d = (count_d != FULL_CNT);

    if (miss_s) begin
      squash_d = SQ_LOAD;
    end else if (squash_q != 4'd0) begin
      squash_d = squash_q - 4'd1;
    end else begin
      squash_d = squash_q;
    end
  end

  // Queue storage, pointers, occupancy and squash counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q     <= '0;
      rd_q     <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      squash_q <= 4'd0;
    end else begin
      if (push_s) begin
        mem_q[wr_q] <= new_rec_s;
        wr_q        <= wr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_q <= rd_q + PTR_W'(1);
      end
      count_q  <= count_d;
      ready_q  <= ready_d;
      squash_q <= squash_d;
    end
  end

  // Redirect pulse and corrected PC (PC holds between pulses)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      redir_q    <= 1'b0;
      redir_pc_q <= 32'd0;
    end else begin
      redir_q <= miss_s;
      if (miss_s) begin
        redir_pc_q <= ex_taken ? ex_target : npc_s;
      end
    end
  end

  // Update-port register: strobes pulse on pop, data holds otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upd_q  <= 1'b0;
      rec_q  <= 1'b0;
      dir_q  <= 1'b0;
      miss_q <= 1'b0;
      pc_q   <= 32'd0;
      tgt_q  <= 32'd0;
      meta_q <= '0;
    end else if (pop_s) begin
      upd_q  <= mem_q[rd_q].upd;
      rec_q  <= mem_q[rd_q].rec;
      dir_q  <= mem_q[rd_q].dir;
      miss_q <= mem_q[rd_q].miss;
      pc_q   <= mem_q[rd_q].pc;
      tgt_q  <= mem_q[rd_q].target;
      meta_q <= mem_q[rd_q].meta;
    end else begin
      upd_q <= 1'b0;
      rec_q <= 1'b0;
    end
  end

  assign ex_ready                       = ready_q;
  assign fetch_redirect                 = redir_q;
  assign fetch_redirect_PC              = redir_pc_q;
  assign execute_bpredictor_update      = upd_q;
  assign execute_bpredictor_recover_ras = rec_q;
  assign execute_bpredictor_dir         = dir_q;
  assign execute_bpredictor_miss        = miss_q;
  assign execute_bpredictor_PC          = pc_q;
  assign execute_bpredictor_target      = tgt_q;
  assign execute_bpredictor_meta        = meta_q;

endmodule
